// File: rtl/filter_pkg.sv
// Shared definitions for the multichannel filter scheduler: widths and FSM encoding.
package filter_pkg;

   localparam int FILTER_OUT_W = 24;
   localparam int CH_W         = 2;
   localparam int SAMPLE_W     = 12;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_NEXT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/signed_to_mag.sv
// Combinational two's-complement to magnitude conversion, MSB of the result always 0.
module signed_to_mag
   import filter_pkg::*;
#(
   parameter int W = FILTER_OUT_W
) (
   input  logic signed [W-1:0] din_i,
   output logic        [W-1:0] mag_o
);

   // Negate the low W-1 bits; the most negative input has no positive twin and saturates.
   function automatic logic [W-1:0] to_mag(input logic [W-1:0] x);
      logic [W-2:0] low;
      logic [W-2:0] neg;
      low = x[W-2:0];
      neg = -low;
      if (!x[W-1])
         return x;
      if (low == '0)
         return {1'b0, {(W-1){1'b1}}};
      return {1'b0, neg};
   endfunction

   assign mag_o = to_mag(din_i);

endmodule

// File: rtl/filter_channel_sched.sv
// Frame scheduler: time-multiplexes four samples through an external multichannel FIR
// and collects per-channel result magnitudes.
module filter_channel_sched
   import filter_pkg::*;
#(
   parameter int FILTEROUTWITH = FILTER_OUT_W,
   parameter int NCH           = 4,
   parameter int WAIT_MAX      = 255
) (
   input  logic                     clk1,
   input  logic                     rst,
   input  logic [SAMPLE_W-1:0]      signal_nco,
   input  logic [SAMPLE_W-1:0]      signal_out_6Hz_decimate,
   input  logic [SAMPLE_W-1:0]      signal_out_15Hz_decimate,
   input  logic [SAMPLE_W-1:0]      signal_out_mix_decimate,
   input  logic                     signal_enable_decimate,
   output logic [SAMPLE_W:0]        fir_sink_data,
   output logic                     fir_sink_valid,
   output logic [CH_W-1:0]          fir_sink_channel,
   input  logic [FILTEROUTWITH-1:0] fir_source_data,
   input  logic                     fir_source_valid,
   input  logic [CH_W-1:0]          fir_source_channel,
   output logic [FILTEROUTWITH-1:0] ch_data_0,
   output logic [FILTEROUTWITH-1:0] ch_data_1,
   output logic [FILTEROUTWITH-1:0] ch_data_2,
   output logic [FILTEROUTWITH-1:0] ch_data_3,
   output logic [NCH-1:0]           ch_valid,
   output logic                     frame_valid,
   output logic                     overrun,
   output logic                     timeout_err
);

   localparam int                CNT_W    = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_MAX - 1);
   localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NCH - 1);

   logic [2:0]               sync_q;
   logic                     frame_start;
   state_t                   state_q, state_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [SAMPLE_W-1:0]      buf_q [4];
   logic [SAMPLE_W-1:0]      buf_d [4];
   logic [FILTEROUTWITH-1:0] mag;
   logic [FILTEROUTWITH-1:0] ch_data_q [4];
   logic [NCH-1:0]           ch_valid_q;
   logic                     frame_valid_q;
   logic                     overrun_q;
   logic                     timeout_q;
   logic [SAMPLE_W:0]        sink_data_q;
   logic                     sink_valid_q;
   logic [CH_W-1:0]          sink_ch_q;
   logic                     accept;
   logic                     timeout_hit;

   assign frame_start = sync_q[1] & ~sync_q[2];
   assign accept      = (state_q == ST_WAIT) && fir_source_valid && (fir_source_channel == ch_q);
   // A result arriving on the last allowed cycle still wins over the timeout.
   assign timeout_hit = (state_q == ST_WAIT) && !accept && (cnt_q == CNT_LAST);

   signed_to_mag #(.W(FILTEROUTWITH)) u_mag (
      .din_i (fir_source_data),
      .mag_o (mag)
   );

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               buf_d[0] = signal_nco;
               buf_d[1] = signal_out_6Hz_decimate;
               buf_d[2] = signal_out_15Hz_decimate;
               buf_d[3] = signal_out_mix_decimate;
               ch_d     = '0;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (accept || timeout_hit)
               state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (ch_q < CH_LAST) begin
               ch_d    = ch_q + 1'b1;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ch_d    = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         sync_q        <= '0;
         state_q       <= ST_IDLE;
         ch_q          <= '0;
         cnt_q         <= '0;
         for (int i = 0; i < 4; i++) begin
            buf_q[i]     <= '0;
            ch_data_q[i] <= '0;
         end
         ch_valid_q    <= '0;
         frame_valid_q <= 1'b0;
         sink_valid_q  <= 1'b0;
         sink_data_q   <= '0;
         sink_ch_q     <= '0;
         overrun_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         sync_q        <= {sync_q[1:0], signal_enable_decimate};
         state_q       <= state_d;
         ch_q          <= ch_d;
         cnt_q         <= cnt_d;
         buf_q         <= buf_d;
         if (accept)
            ch_data_q[ch_q] <= mag;
         ch_valid_q    <= accept ? (NCH'(1) << ch_q) : '0;
         frame_valid_q <= (state_d == ST_DONE);
         // Sink registers load on entry to ISSUE so the strobe coincides with that state.
         sink_valid_q  <= (state_d == ST_ISSUE);
         if (state_d == ST_ISSUE) begin
            sink_data_q <= {1'b0, buf_d[ch_d]};
            sink_ch_q   <= ch_d;
         end
         overrun_q     <= overrun_q | (frame_start && (state_q != ST_IDLE));
         timeout_q     <= timeout_q | timeout_hit;
      end
   end

   assign fir_sink_data    = sink_data_q;
   assign fir_sink_valid   = sink_valid_q;
   assign fir_sink_channel = sink_ch_q;
   assign ch_data_0        = ch_data_q[0];
   assign ch_data_1        = ch_data_q[1];
   assign ch_data_2        = ch_data_q[2];
   assign ch_data_3        = ch_data_q[3];
   assign ch_valid         = ch_valid_q;
   assign frame_valid      = frame_valid_q;
   assign overrun          = overrun_q;
   assign timeout_err      = timeout_q;

endmodule

// File: tb/tb_filter_channel_sched.sv
// Directed bench for filter_channel_sched with a delayed-echo FIR model.
module tb_filter_channel_sched;

   localparam int W = 24;

   logic          clk1 = 1'b0;
   logic          rst;
   logic [11:0]   s0, s1, s2, s3;
   logic          en;
   logic [12:0]   fir_sink_data;
   logic          fir_sink_valid;
   logic [1:0]    fir_sink_channel;
   logic [W-1:0]  fir_source_data;
   logic          fir_source_valid;
   logic [1:0]    fir_source_channel;
   logic [W-1:0]  ch_data_0, ch_data_1, ch_data_2, ch_data_3;
   logic [3:0]    ch_valid;
   logic          frame_valid, overrun, timeout_err;

   filter_channel_sched #(.FILTEROUTWITH(W), .NCH(4), .WAIT_MAX(255)) dut (
      .clk1                     (clk1),
      .rst                      (rst),
      .signal_nco               (s0),
      .signal_out_6Hz_decimate  (s1),
      .signal_out_15Hz_decimate (s2),
      .signal_out_mix_decimate  (s3),
      .signal_enable_decimate   (en),
      .fir_sink_data            (fir_sink_data),
      .fir_sink_valid           (fir_sink_valid),
      .fir_sink_channel         (fir_sink_channel),
      .fir_source_data          (fir_source_data),
      .fir_source_valid         (fir_source_valid),
      .fir_source_channel       (fir_source_channel),
      .ch_data_0                (ch_data_0),
      .ch_data_1                (ch_data_1),
      .ch_data_2                (ch_data_2),
      .ch_data_3                (ch_data_3),
      .ch_valid                 (ch_valid),
      .frame_valid              (frame_valid),
      .overrun                  (overrun),
      .timeout_err              (timeout_err)
   );

   always #10 clk1 = ~clk1;

   int checks = 0;
   int errors = 0;

   // Monitor state
   int          cyc = 0;
   int          fv_cnt, fv_cyc, chv3_cyc, sink_cnt, first_sink_ch;
   int          chv_cnt [4];
   int          sink_cyc [4];
   logic [12:0] sink_seen [4];

   // FIR model controls
   bit          model_en;
   logic [3:0]  skip;
   logic [3:0]  ovr_en;
   logic [W-1:0] ovr_val [4];
   bit          pend;
   int          pend_cnt;
   logic [1:0]  pend_ch;
   logic [W-1:0] pend_data;

   typedef struct packed {
      logic [3:0][11:0]  smp;
      logic [3:0]        oen;
      logic [3:0][W-1:0] ovr;
      logic [3:0][W-1:0] exp;
   } vec_t;

   vec_t vec [5];

   function automatic vec_t mk(input logic [11:0] a, b, c, d, input logic [3:0] oen,
                               input logic [W-1:0] o0, o1, o2, o3, e0, e1, e2, e3);
      vec_t v;
      v.smp = {d, c, b, a};
      v.oen = oen;
      v.ovr = {o3, o2, o1, o0};
      v.exp = {e3, e2, e1, e0};
      return v;
   endfunction

   function automatic logic [W-1:0] get_ch(input int i);
      case (i)
         0: return ch_data_0;
         1: return ch_data_1;
         2: return ch_data_2;
         default: return ch_data_3;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk1);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic clear_mon();
      fv_cnt = 0; fv_cyc = 0; chv3_cyc = 0; sink_cnt = 0; first_sink_ch = -1;
      for (int i = 0; i < 4; i++) begin
         chv_cnt[i] = 0; sink_cyc[i] = 0; sink_seen[i] = '0;
      end
   endtask

   task automatic start_frame(input logic [11:0] a, b, c, d);
      s0 = a; s1 = b; s2 = c; s3 = d;
      en = 1'b1;
      tick(4);
      en = 1'b0;
   endtask

   task automatic wait_frame(input int budget);
      int n = 0;
      int f0 = fv_cnt;
      while (fv_cnt == f0 && n < budget) begin
         tick(1);
         n++;
      end
      check("frame_done", 32'(fv_cnt != f0), 32'd1);
      tick(3);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ch0"}, ch_data_0, 0);
      check({tag, "_ch1"}, ch_data_1, 0);
      check({tag, "_ch2"}, ch_data_2, 0);
      check({tag, "_ch3"}, ch_data_3, 0);
      check({tag, "_chv"}, ch_valid, 0);
      check({tag, "_fv"}, frame_valid, 0);
      check({tag, "_skv"}, fir_sink_valid, 0);
      check({tag, "_skd"}, fir_sink_data, 0);
      check({tag, "_skc"}, fir_sink_channel, 0);
      check({tag, "_ovr"}, overrun, 0);
      check({tag, "_tmo"}, timeout_err, 0);
   endtask

   task automatic inject(input logic [1:0] ch, input logic [W-1:0] d);
      fir_source_valid   = 1'b1;
      fir_source_channel = ch;
      fir_source_data    = d;
      tick(1);
      fir_source_valid   = 1'b0;
   endtask

   // Monitor: samples on the falling edge, away from the active edge
   initial begin
      forever begin
         @(negedge clk1);
         cyc++;
         if (frame_valid) begin fv_cnt++; fv_cyc = cyc; end
         for (int i = 0; i < 4; i++)
            if (ch_valid[i]) chv_cnt[i]++;
         if (ch_valid[3]) chv3_cyc = cyc;
         if (fir_sink_valid) begin
            if (sink_cnt == 0) first_sink_ch = int'(fir_sink_channel);
            sink_cnt++;
            sink_seen[fir_sink_channel] = fir_sink_data;
            sink_cyc[fir_sink_channel]  = cyc;
         end
      end
   end

   // FIR model: echoes the sign-extended sink word (or an override) 10 cycles later
   initial begin
      pend = 0; pend_cnt = 0;
      forever begin
         @(posedge clk1);
         #1;
         if (model_en) begin
            fir_source_valid = 1'b0;
            if (pend) begin
               if (pend_cnt == 0) begin
                  fir_source_valid   = 1'b1;
                  fir_source_channel = pend_ch;
                  fir_source_data    = pend_data;
                  pend = 0;
               end else begin
                  pend_cnt--;
               end
            end
            if (fir_sink_valid && !skip[fir_sink_channel]) begin
               pend      = 1;
               pend_cnt  = 9;
               pend_ch   = fir_sink_channel;
               pend_data = ovr_en[fir_sink_channel] ? ovr_val[fir_sink_channel]
                                                    : {{11{fir_sink_data[12]}}, fir_sink_data};
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; s0 = '0; s1 = '0; s2 = '0; s3 = '0;
      fir_source_valid = 1'b0; fir_source_channel = '0; fir_source_data = '0;
      model_en = 1; skip = '0; ovr_en = '0;
      for (int i = 0; i < 4; i++) ovr_val[i] = '0;
      clear_mon();

      vec[0] = mk(12'h001, 12'h002, 12'h003, 12'h004, 4'b0000, 0, 0, 0, 0,
                  24'h1, 24'h2, 24'h3, 24'h4);
      vec[1] = mk(12'h005, 12'h006, 12'h007, 12'h008, 4'b0010, 0, 24'hFFFFF6, 0, 0,
                  24'h5, 24'hA, 24'h7, 24'h8);
      vec[2] = mk(12'h100, 12'h200, 12'h300, 12'h400, 4'b1111,
                  24'h800001, 24'h800000, 24'h7FFFFF, 24'hFFFFFF,
                  24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h000001);
      vec[3] = mk(12'hFFF, 12'h800, 12'h000, 12'hABC, 4'b0000, 0, 0, 0, 0,
                  24'hFFF, 24'h800, 24'h000, 24'hABC);
      vec[4] = mk(12'h010, 12'h020, 12'h030, 12'h040, 4'b0101, 24'h000000, 0, 24'hC00000, 0,
                  24'h0, 24'h20, 24'h400000, 24'h40);

      tick(2);
      rst = 1'b0;
      check_all_zero("reset");

      // Table-driven frames
      for (int r = 0; r < 5; r++) begin
         ovr_en = vec[r].oen;
         for (int i = 0; i < 4; i++) ovr_val[i] = vec[r].ovr[i];
         clear_mon();
         start_frame(vec[r].smp[0], vec[r].smp[1], vec[r].smp[2], vec[r].smp[3]);
         wait_frame(1000);
         for (int i = 0; i < 4; i++) begin
            check($sformatf("r%0d_sink%0d", r, i), sink_seen[i], {1'b0, vec[r].smp[i]});
            check($sformatf("r%0d_data%0d", r, i), get_ch(i), vec[r].exp[i]);
            check($sformatf("r%0d_chv%0d", r, i), chv_cnt[i], 1);
         end
         check($sformatf("r%0d_fvcnt", r), fv_cnt, 1);
         check($sformatf("r%0d_first", r), first_sink_ch, 0);
         if (r == 0) check("r0_fv_after_chv3", fv_cyc - chv3_cyc, 1);
      end
      ovr_en = '0;
      check("tbl_overrun", overrun, 0);
      check("tbl_timeout", timeout_err, 0);

      // Overrun: second enable edge 5 cycles after the first
      do_reset();
      clear_mon();
      s0 = 12'h011; s1 = 12'h022; s2 = 12'h033; s3 = 12'h044;
      en = 1'b1;
      tick(3);
      check("ovr_before", overrun, 0);
      en = 1'b0;
      tick(1);
      s0 = 12'h055; s1 = 12'h066; s2 = 12'h077; s3 = 12'h088;
      tick(1);
      en = 1'b1;
      tick(4);
      check("ovr_set", overrun, 1);
      en = 1'b0;
      wait_frame(1000);
      check("ovr_d0", ch_data_0, 24'h11);
      check("ovr_d1", ch_data_1, 24'h22);
      check("ovr_d2", ch_data_2, 24'h33);
      check("ovr_d3", ch_data_3, 24'h44);
      check("ovr_sink3", sink_seen[3], 13'h044);
      check("ovr_fvcnt", fv_cnt, 1);
      check("ovr_sticky", overrun, 1);

      // Timeout on ch2
      do_reset();
      clear_mon();
      start_frame(12'h001, 12'h002, 12'h003, 12'h004);
      wait_frame(1000);
      check("tmo_before", timeout_err, 0);
      clear_mon();
      skip = 4'b0100;
      start_frame(12'h021, 12'h022, 12'h023, 12'h024);
      wait_frame(2000);
      skip = '0;
      check("tmo_flag", timeout_err, 1);
      check("tmo_d0", ch_data_0, 24'h21);
      check("tmo_d1", ch_data_1, 24'h22);
      check("tmo_d2_kept", ch_data_2, 24'h3);
      check("tmo_d3", ch_data_3, 24'h24);
      check("tmo_chv2", chv_cnt[2], 0);
      check("tmo_chv3", chv_cnt[3], 1);
      check("tmo_sink3", sink_seen[3], 13'h024);
      check("tmo_gap", sink_cyc[3] - sink_cyc[2], 257);
      check("tmo_fvcnt", fv_cnt, 1);

      // Mismatched tag is ignored
      do_reset();
      clear_mon();
      model_en = 0;
      start_frame(12'h031, 12'h032, 12'h033, 12'h034);
      begin
         int n = 0;
         while (sink_cnt < 1 && n < 50) begin tick(1); n++; end
      end
      check("mis_issue0", sink_cnt, 1);
      tick(3);
      inject(2'd3, 24'h000999);
      tick(2);
      check("mis_chv0", chv_cnt[0], 0);
      check("mis_chv3", chv_cnt[3], 0);
      check("mis_d0", ch_data_0, 0);
      check("mis_d3", ch_data_3, 0);
      inject(2'd0, 24'h000031);
      model_en = 1;
      tick(1);
      check("mis_acc_d0", ch_data_0, 24'h31);
      check("mis_acc_chv0", chv_cnt[0], 1);
      wait_frame(1000);
      check("mis_d1", ch_data_1, 24'h32);
      check("mis_d3b", ch_data_3, 24'h34);
      check("mis_fvcnt", fv_cnt, 1);

      // Reset while waiting on ch1
      do_reset();
      clear_mon();
      start_frame(12'h041, 12'h042, 12'h043, 12'h044);
      begin
         int n = 0;
         while (sink_cnt < 2 && n < 100) begin tick(1); n++; end
      end
      check("rst_issue1", sink_cnt, 2);
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_all_zero("rstmid");
      tick(20);
      check("rst_nofv", fv_cnt, 0);
      check("rst_nochv1", chv_cnt[1], 0);
      check("rst_d1", ch_data_1, 0);
      clear_mon();
      start_frame(12'h051, 12'h052, 12'h053, 12'h054);
      wait_frame(1000);
      check("rst_first", first_sink_ch, 0);
      check("rst_d0", ch_data_0, 24'h51);
      check("rst_d1b", ch_data_1, 24'h52);
      check("rst_d2", ch_data_2, 24'h53);
      check("rst_d3", ch_data_3, 24'h54);
      check("rst_fvcnt", fv_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
